// File: rtl/qgemm_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qgemm_sched_pkg
// Description : Shared types and constant helpers for the quantize tile
//               scheduler. It holds the scheduler state encoding, the
//               requester index constants and the beat-count derivation
//               helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package qgemm_sched_pkg;

  // Requester indices. A feeds the A-operand path and B feeds the B-operand path.
  localparam int unsigned REQ_A = 0;
  localparam int unsigned REQ_B = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_FILL  = 3'd2,
    ST_SCALE = 3'd3,
    ST_EMIT  = 3'd4,
    ST_NEXT  = 3'd5
  } sched_state_e;

  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Number of stream beats needed to move one MAT x MAT tile.
  function automatic int unsigned in_beats_f(input int unsigned mat,
                                             input int unsigned lanes);
    return (mat * mat + lanes - 1) / lanes;
  endfunction

  // Counter width able to hold beat index IN_BEATS-1. It is never narrower than 1 bit.
  function automatic int unsigned beat_cnt_w_f(input int unsigned beats);
    return (beats > 1) ? clog2_f(beats) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin picker. When both requests are active,
//               the requester at the pointer wins. Otherwise the only
//               active requester wins. The pointer flips on each
//               completion strobe.
// Ports       : clk, rst        - clock and synchronous active-high reset
//               req_i[1:0]      - request vector
//               advance_i       - completion strobe that flips the pointer
//               grant_o         - index of the winning requester
//               any_o           - at least one request is active
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import qgemm_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic       grant_o,
  output logic       any_o
);

  logic ptr_q;

  assign grant_o = req_i[ptr_q] ? ptr_q : ~ptr_q;
  assign any_o   = |req_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'(REQ_A);
    end else if (advance_i) begin
      ptr_q <= ~ptr_q;
    end
  end

endmodule
`default_nettype wire

// File: rtl/quant_tile_sched.sv
`default_nettype none
// ============================================================================
// Module      : quant_tile_sched
// Description : Shares one quantize tile engine between two requesters.
//               Jobs of N tiles are granted round-robin. For each tile the
//               engine is started once, and the scheduler then routes the
//               input stream (FILL), the scale handshake (SCALE) and the
//               output stream (EMIT) to the owner. It signals done after the
//               last tile. All routing is combinational pass-through.
// Optional    : QSCHED_STALL_CNT_EN adds stall_cnt_o, a saturating count of
//               owner stall cycles in FILL (no input valid) and in EMIT
//               (no output ready).
// Ports       : req_valid_i/req_ntiles_i/req_ready_o - job request and accept
//               done_o, owner_o, busy_o              - job status
//               s_valid_i/s_ready_o/s_data_i         - per-requester input
//               qa_*                                 - engine side
//               scl_valid_o/scl_ready_i              - routed scale handshake
//               m_valid_o/m_ready_i                  - routed output stream
// Revision    : 1.0 - initial release
// ============================================================================
module quant_tile_sched
  import qgemm_sched_pkg::*;
#(
  parameter int unsigned LANES_NUM  = 16,
  parameter int unsigned MAT_SIZE   = 16,
  parameter int unsigned FP_DATA_W  = 32,
  parameter int unsigned TILE_CNT_W = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [1:0]                        req_valid_i,
  input  logic [2*TILE_CNT_W-1:0]           req_ntiles_i,
  output logic [1:0]                        req_ready_o,
  output logic [1:0]                        done_o,
  output logic                              owner_o,
  output logic                              busy_o,
  input  logic [1:0]                        s_valid_i,
  output logic [1:0]                        s_ready_o,
  input  logic [2*LANES_NUM*FP_DATA_W-1:0]  s_data_i,
  output logic                              qa_start_o,
  output logic                              qa_s_valid_o,
  input  logic                              qa_s_ready_i,
  output logic [LANES_NUM*FP_DATA_W-1:0]    qa_s_data_o,
  input  logic                              qa_scl_valid_i,
  output logic                              qa_scl_ready_o,
  input  logic                              qa_m_valid_i,
  output logic                              qa_m_ready_o,
  output logic [1:0]                        scl_valid_o,
  input  logic [1:0]                        scl_ready_i,
  output logic [1:0]                        m_valid_o,
  input  logic [1:0]                        m_ready_i
`ifdef QSCHED_STALL_CNT_EN
  ,
  output logic [31:0]                       stall_cnt_o
`endif
);

  localparam int unsigned IN_BEATS = in_beats_f(MAT_SIZE, LANES_NUM);
  localparam int unsigned BEAT_W   = beat_cnt_w_f(IN_BEATS);
  localparam int unsigned DATA_W   = LANES_NUM * FP_DATA_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(IN_BEATS - 1);

  sched_state_e            state_q, state_d;
  logic                    owner_q, owner_d;
  logic [TILE_CNT_W-1:0]   remaining_q, remaining_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;

  logic                    grant;
  logic                    any_req;
  logic                    job_done;
  logic [TILE_CNT_W-1:0]   ntiles_grant;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_valid_i),
    .advance_i (job_done),
    .grant_o   (grant),
    .any_o     (any_req)
  );

  assign ntiles_grant = grant ? req_ntiles_i[REQ_B*TILE_CNT_W +: TILE_CNT_W]
                              : req_ntiles_i[REQ_A*TILE_CNT_W +: TILE_CNT_W];

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    remaining_d    = remaining_q;
    beat_d         = beat_q;
    req_ready_o    = '0;
    done_o         = '0;
    qa_start_o     = 1'b0;
    qa_s_valid_o   = 1'b0;
    s_ready_o      = '0;
    qa_scl_ready_o = 1'b0;
    scl_valid_o    = '0;
    qa_m_ready_o   = 1'b0;
    m_valid_o      = '0;
    job_done       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A grant made while reset is asserted would be thrown away, so the
        // accept pulse is not shown to the requester during reset.
        if (any_req && !rst) begin
          req_ready_o[grant] = 1'b1;
          owner_d            = grant;
          remaining_d        = ntiles_grant;
          if (ntiles_grant == '0) begin
            done_o[grant] = 1'b1;
            job_done      = 1'b1;
          end else begin
            state_d = ST_START;
          end
        end
      end
      ST_START: begin
        qa_start_o = 1'b1;
        beat_d     = '0;
        state_d    = ST_FILL;
      end
      ST_FILL: begin
        qa_s_valid_o       = s_valid_i[owner_q];
        s_ready_o[owner_q] = qa_s_ready_i;
        if (s_valid_i[owner_q] && qa_s_ready_i) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = ST_SCALE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_SCALE: begin
        scl_valid_o[owner_q] = qa_scl_valid_i;
        qa_scl_ready_o       = scl_ready_i[owner_q];
        if (qa_scl_valid_i && scl_ready_i[owner_q]) begin
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        m_valid_o[owner_q] = qa_m_valid_i;
        qa_m_ready_o       = m_ready_i[owner_q];
        if (qa_m_valid_i && m_ready_i[owner_q]) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = ST_NEXT;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_NEXT: begin
        remaining_d = remaining_q - TILE_CNT_W'(1);
        if (remaining_q == TILE_CNT_W'(1)) begin
          // A job cut short by reset must never report completion.
          done_o[owner_q] = !rst;
          job_done        = !rst;
          state_d         = ST_IDLE;
        end else begin
          state_d = ST_START;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      remaining_q <= '0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      remaining_q <= remaining_d;
      beat_q      <= beat_d;
    end
  end

  assign owner_o = owner_q;
  assign busy_o  = (state_q != ST_IDLE);

  // The data bus is held at zero outside FILL, so idle and reset present a
  // quiet bus to the engine.
  assign qa_s_data_o = (state_q != ST_FILL) ? '0 :
                       owner_q ? s_data_i[REQ_B*DATA_W +: DATA_W]
                               : s_data_i[REQ_A*DATA_W +: DATA_W];

`ifdef QSCHED_STALL_CNT_EN
  logic [31:0] stall_q;
  logic        stall_inc;

  assign stall_inc = ((state_q == ST_FILL) && !s_valid_i[owner_q]) ||
                     ((state_q == ST_EMIT) && !m_ready_i[owner_q]);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (stall_inc && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  // This build has no stall counter.
`endif

endmodule
`default_nettype wire

// File: doc/quant_tile_sched.md
Name: quant_tile_sched

Overview:
- Arbitrates one shared quantize tile engine between two requesters (A-operand and B-operand quantization paths of the QGEMM datapath).
- Each requester submits a job of N tiles. The scheduler:
  - grants jobs round-robin,
  - pulses the engine start once per tile,
  - routes the input stream, scale handshake and output handshake to the owner,
  - counts beats to track the engine phases,
  - signals job completion.
- Sits between the operand DMA/unpack stage and the quantize engine; data and scale buses from the engine fan out unmodified.

Parameters:
- LANES_NUM, 16, lanes per stream beat
- MAT_SIZE, 16, tile edge; beats per tile IN_BEATS = ceil(MAT_SIZE*MAT_SIZE/LANES_NUM)
- FP_DATA_W, 32, lane width
- TILE_CNT_W, 8, width of tiles-per-job field

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid_i  in  2  job request per requester
- req_ntiles_i  in  2*TILE_CNT_W  tiles per job, slice i = requester i
- req_ready_o  out  2  job accept, one-cycle pulse
- done_o  out  2  job complete, one-cycle pulse
- owner_o  out  1  current owner index, valid while busy_o
- busy_o  out  1  job in progress
- s_valid_i  in  2  per-requester input stream valid
- s_ready_o  out  2  per-requester input stream ready
- s_data_i  in  2*LANES_NUM*FP_DATA_W  per-requester input data
- qa_start_o  out  1  engine start pulse
- qa_s_valid_o  out  1  engine input valid
- qa_s_ready_i  in  1  engine input ready
- qa_s_data_o  out  LANES_NUM*FP_DATA_W  engine input data (owner's slice)
- qa_scl_valid_i  in  1  engine scale valid
- qa_scl_ready_o  out  1  engine scale ready
- qa_m_valid_i  in  1  engine output valid
- qa_m_ready_o  out  1  engine output ready
- scl_valid_o  out  2  scale valid routed to owner
- scl_ready_i  in  2  scale ready from requesters
- m_valid_o  out  2  quantized stream valid routed to owner
- m_ready_i  in  2  quantized stream ready from requesters

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, rr_ptr=0, all outputs 0, owner_o=0.
  - Reset mid-job abandons the job; no done_o pulse.
  - The engine shares the reset: its rstnn = ~rst.
- States: IDLE, START, FILL, SCALE, EMIT, NEXT.
- IDLE:
  - If any req_valid_i: grant = rr_ptr if req_valid_i[rr_ptr], else the other requester.
  - Pulse req_ready_o[grant]; latch owner and ntiles.
  - ntiles==0: pulse done_o[grant] in the same cycle, stay IDLE, toggle rr_ptr.
  - Otherwise go to START.
- START: qa_start_o=1 for exactly one cycle -> FILL; beat counter cleared.
- FILL:
  - qa_s_valid_o = s_valid_i[owner]; s_ready_o[owner] = qa_s_ready_i; the non-owner's s_ready_o stays 0.
  - Count accepted beats; on beat IN_BEATS-1 -> SCALE.
- SCALE:
  - scl_valid_o[owner] = qa_scl_valid_i; qa_scl_ready_o = scl_ready_i[owner].
  - On handshake -> EMIT.
- EMIT:
  - m_valid_o[owner] = qa_m_valid_i; qa_m_ready_o = m_ready_i[owner].
  - Count beats; on beat IN_BEATS-1 -> NEXT.
- NEXT:
  - Decrement remaining. If remaining becomes 0: pulse done_o[owner], toggle rr_ptr -> IDLE. Otherwise -> START.
  - Tile overhead is 2 cycles (NEXT + START).
- Routing: all handshakes are combinational pass-through, so there is no added beat latency.
- Non-owner: all routed valids/readies are 0. Requests arriving mid-job wait in IDLE arbitration.
- busy_o = (state != IDLE).
- Simultaneous requests in IDLE: the rr_ptr requester wins; the loser is granted on the next IDLE visit.
- req_ntiles_i is sampled only at grant; later changes are ignored.

Optional Feature:
- Macro: QSCHED_STALL_CNT_EN.
- Defined:
  - Output stall_cnt_o, 32 bits.
  - Increments each cycle in FILL with s_valid_i[owner]=0, or in EMIT with m_ready_i[owner]=0.
  - Saturates at all-ones; cleared by rst.
- Undefined: the port and the counter are absent.

Decomposition:
- Package qgemm_sched_pkg holds:
  - the state enum,
  - IN_BEATS and beat-counter width derivation (clog2 function),
  - the requester-index constants.
- Sub-module rr_arb2: 2-way round-robin picker with pointer update on a completion strobe.

Test Plan:
- Req0 only, ntiles=1, MAT_SIZE=16, LANES=16, no backpressure -> one qa_start_o pulse, 16 FILL beats, scale handshake, 16 EMIT beats, done_o[0] one cycle after the last EMIT beat.
- Both requesters assert in the same cycle after reset, ntiles=2 each -> req0 served first (4 starts total); req1 granted on the following IDLE; done_o order 0 then 1.
- Req1 ntiles=0 -> req_ready_o[1] and done_o[1] in the same cycle; qa_start_o never asserts.
- Random s_valid_i/m_ready_i/scl_ready_i gaps on the owner -> beat counts stay exact; non-owner s_ready_o, m_valid_o and scl_valid_o stay 0 throughout.
- rst asserted mid-EMIT of tile 2 of 3 -> all outputs 0 next cycle; no done_o; a new request is then served from START.
- With QSCHED_STALL_CNT_EN: hold m_ready_i[owner]=0 for 5 EMIT cycles -> stall_cnt_o = 5.
